bcd_digit_streamer: RTL and testbench
=====================================

// Module: bcd_digit_streamer
// PURPOSE
//   Sequential stage fed by the binary-to-BCD converter. Captures a packed BCD
//   word on a load strobe and emits its digits one per handshake, MSD first,
//   over a valid/ready interface to the VGA character renderer.
//   Flags leading zeros so the renderer can blank them while column positions
//   stay fixed.
// PARAMETERS
//   NUM_BCD     3   number of 4-bit digits in bcd_in (>=1)
//   LEAD_BLANK  1   1: generate digit_blank for leading zeros; 0: digit_blank tied 0
//   IDX_W       localparam = max(1, clog2(NUM_BCD)), width of digit_idx
// PORTS
//   clk          in   1            system clock, all logic on rising edge
//   rst_n        in   1            asynchronous active-low reset
//   bcd_in       in   4*NUM_BCD    packed BCD, digit i at [4i+3:4i], digit 0 = LSD
//   load         in   1            capture bcd_in and start a stream (accepted only when !busy)
//   busy         out  1            1 from cycle after accepted load until last digit handshakes
//   digit_valid  out  1            digit/idx/blank/last are valid
//   digit_ready  in   1            downstream accepts the digit this cycle
//   digit        out  4            current BCD digit
//   digit_idx    out  IDX_W        position of current digit (NUM_BCD-1 .. 0)
//   digit_blank  out  1            current digit is a leading zero
//   digit_last   out  1            current digit is digit 0
//   done         out  1            one-cycle pulse after last digit handshakes
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, shadow reg 0, all outputs 0.
//     Takes effect immediately, also mid-stream. The partial stream is discarded.
//     No done pulse for it.
//   - States: IDLE, STREAM.
//   - IDLE:
//       load=1 -> register bcd_in into shadow, idx<=NUM_BCD-1, go STREAM.
//       digit_valid and busy go 1 on the next cycle (latency 1).
//   - STREAM:
//       digit = shadow[4*idx+:4], digit_last = (idx==0).
//       Handshake = digit_valid & digit_ready.
//       Handshake with idx>0 -> idx<=idx-1, next digit valid next cycle
//       (back-to-back, one digit per cycle at full throughput).
//       Handshake with idx==0 -> go IDLE; digit_valid, busy <= 0; done <= 1 for 1 cycle.
//   - Backpressure: while digit_valid & !digit_ready, digit, digit_idx, digit_blank
//     and digit_last hold stable. digit_valid never drops without a handshake.
//   - load is ignored while busy, including in the cycle of the final handshake.
//     A new load is accepted no earlier than the done cycle; bcd_in changes during
//     a stream have no effect.
//   - Blanking (LEAD_BLANK=1):
//       digit_blank=1 iff digit==0 and all higher digits in shadow ==0, and idx!=0.
//       Digit 0 is never blanked, so value 0 shows as a single "0".
//       Blanked digits are still emitted and handshaked.
//   - Digit codes 10..15: passed through unchanged; treated as non-zero for blanking.
//   - NUM_BCD=1: single digit, digit_last=1 on it, idx constant 0.
//   - done and digit_valid are never high in the same cycle.
// TESTING
//   1. bcd_in=12'h205, load, ready=1 -> digits 2,0,5 on 3 consecutive cycles;
//      idx 2,1,0; blank 0,0,0; last on 5; done next cycle.
//   2. bcd_in=12'h007, ready=1 -> digits 0,0,7; blank 1,1,0.
//   3. bcd_in=12'h000 -> digits 0,0,0; blank 1,1,0 (LSD not blanked).
//   4. bcd_in=12'h319, ready low 3 cycles during digit 1 -> digit=1, idx=1 held
//      4 cycles; stream completes 3,1,9.
//   5. load with 12'h456 while busy on 12'h123, and load in the last-handshake
//      cycle -> both ignored; only 1,2,3 emitted.
//   6. rst_n low at idx=1 of 12'h888 -> outputs 0 immediately, no done.
//      After release, load 12'h042 -> 0(blank),4,2.

Source files
------------

// File: rtl/bcd_digit_streamer.sv
// Captures a packed BCD word on load and streams its digits MSD first over
// valid/ready, flagging leading zeros so the renderer can blank them in place.
module bcd_digit_streamer #(
    parameter int NUM_BCD    = 3,
    parameter bit LEAD_BLANK = 1'b1,
    localparam int IDX_W     = (NUM_BCD > 1) ? $clog2(NUM_BCD) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NUM_BCD-1:0]   bcd_in,
    input  logic                   load,
    output logic                   busy,
    output logic                   digit_valid,
    input  logic                   digit_ready,
    output logic [3:0]             digit,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   digit_blank,
    output logic                   digit_last,
    output logic                   done
);

    // state  | meaning
    // IDLE   | waiting for load; done pulses here for one cycle after a stream
    // STREAM | presenting shadow digit idx, stepping down on each handshake
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state, state_nxt;
    logic [4*NUM_BCD-1:0]   shadow, shadow_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic                   done_q, done_nxt;
    logic                   active, hs, cur_last, higher_zero;
    logic [3:0]             cur_digit;

    assign active    = (state == STREAM);
    assign cur_digit = shadow[4*idx +: 4];
    assign cur_last  = (idx == '0);
    assign hs        = active & digit_ready;

    // Codes 10..15 are non-zero here, so they stop the leading-zero run.
    always_comb begin
        higher_zero = 1'b1;
        for (int j = 0; j < NUM_BCD; j++) begin
            if ((IDX_W'(j) > idx) && (shadow[4*j +: 4] != 4'd0))
                higher_zero = 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        idx_nxt    = idx;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    shadow_nxt = bcd_in;
                    idx_nxt    = IDX_W'(NUM_BCD - 1);
                    state_nxt  = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (cur_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx - IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
        end
    end

    // Digit outputs are gated so everything reads 0 outside a stream.
    assign busy        = active;
    assign digit_valid = active;
    assign digit       = active ? cur_digit : 4'd0;
    assign digit_idx   = active ? idx : '0;
    assign digit_last  = active & cur_last;
    assign digit_blank = LEAD_BLANK && active && !cur_last
                         && (cur_digit == 4'd0) && higher_zero;
    assign done        = done_q;

endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Directed bench for bcd_digit_streamer (NUM_BCD=3): full-rate streams,
// leading-zero blanking, backpressure, ignored loads and mid-stream reset.
module tb_bcd_digit_streamer;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        load;
    logic        busy;
    logic        digit_valid;
    logic        digit_ready;
    logic [3:0]  digit;
    logic [1:0]  digit_idx;
    logic        digit_blank;
    logic        digit_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    bcd_digit_streamer #(.NUM_BCD(3), .LEAD_BLANK(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .load        (load),
        .busy        (busy),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .digit_idx   (digit_idx),
        .digit_blank (digit_blank),
        .digit_last  (digit_last),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " valid"}, 32'(digit_valid), 32'd0);
        check({tag, " busy"},  32'(busy),        32'd0);
        check({tag, " done"},  32'(done),        32'(exp_done));
        check({tag, " digit"}, 32'(digit),       32'd0);
        check({tag, " idx"},   32'(digit_idx),   32'd0);
    endtask

    task automatic check_digit(input string tag, input logic [11:0] exp_d,
                               input logic [2:0] exp_b, input int i);
        check({tag, " valid"}, 32'(digit_valid), 32'd1);
        check({tag, " busy"},  32'(busy),        32'd1);
        check({tag, " done"},  32'(done),        32'd0);
        check({tag, " digit"}, 32'(digit),       32'(exp_d[4*i +: 4]));
        check({tag, " idx"},   32'(digit_idx),   32'(i));
        check({tag, " blank"}, 32'(digit_blank), 32'(exp_b[i]));
        check({tag, " last"},  32'(digit_last),  32'(i == 0));
    endtask

    // Called at a negedge with the DUT idle. Loads val, then walks the stream;
    // digit stall_idx sees stall_n ready-low cycles before its handshake.
    // ign_load drives load with other data mid-stream and in the last handshake.
    task automatic run_stream(input string tag, input logic [11:0] val,
                              input logic [2:0] exp_b, input int stall_idx,
                              input int stall_n, input logic ign_load);
        bcd_in = val;
        load   = 1'b1;
        digit_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        load = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            for (int s = 0; s < ((i == stall_idx) ? stall_n : 0); s++) begin
                digit_ready = 1'b0;
                if (ign_load) begin load = 1'b1; bcd_in = 12'h456; end
                check_digit($sformatf("%s stall d%0d", tag, i), val, exp_b, i);
                @(posedge clk); @(negedge clk);
            end
            digit_ready = 1'b1;
            check_digit($sformatf("%s d%0d", tag, i), val, exp_b, i);
            if (ign_load && i != 2) begin load = 1'b1; bcd_in = 12'h456; end
            @(posedge clk); @(negedge clk);
            load = 1'b0;
        end
        check_idle({tag, " done"}, 1'b1);
        @(posedge clk); @(negedge clk);
        check_idle({tag, " after"}, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bcd_in = 12'h000;
        load = 1'b0;
        digit_ready = 1'b0;
        #1;
        check_idle("reset", 1'b0);
        check("reset last",  32'(digit_last),  32'd0);
        check("reset blank", 32'(digit_blank), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post reset", 1'b0);

        run_stream("t205", 12'h205, 3'b000, -1, 0, 1'b0);
        run_stream("t007", 12'h007, 3'b110, -1, 0, 1'b0);
        run_stream("t000", 12'h000, 3'b110, -1, 0, 1'b0);
        run_stream("t319", 12'h319, 3'b000,  1, 3, 1'b0);
        run_stream("tA05", 12'hA05, 3'b000, -1, 0, 1'b0);
        run_stream("t123", 12'h123, 3'b000,  2, 1, 1'b1);

        // Reset in the middle of a stream: outputs clear at once, no done.
        bcd_in = 12'h888;
        load = 1'b1;
        digit_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        load = 1'b0;
        check_digit("t888 d2", 12'h888, 3'b000, 2);
        @(posedge clk); @(negedge clk);
        check_digit("t888 d1", 12'h888, 3'b000, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("t888 async rst", 1'b0);
        check("t888 rst last", 32'(digit_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle($sformatf("t888 post rst %0d", k), 1'b0);
        end

        run_stream("t042", 12'h042, 3'b100, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
